// File: rtl/ui_io_helpers.sv
// ---------------------------------------------------------------------------
// ui_io_helpers
//   Small board-I/O helpers shared by the filter UI and the kernel datapath.
//
//   bin2hex7seg    : nibble -> active-low 7-segment pattern (combinational)
//   button_input   : one push-button channel, 2-flop synchronizer plus a
//                    one-cycle pulse on each press (falling edge of key_n)
//   round_to_8_bit : signed PRECISION-bit value -> unsigned 8-bit, saturating
//   ui_io_helpers  : top, one button_input per key plus one of each
//                    combinational helper
//
// Top ports:
//   clk      in   system clock (VGA clock domain)
//   reset    in   asynchronous, active-high reset
//   key_n    in   [N_KEYS]    raw push buttons, active-low, asynchronous
//   pressed  out  [N_KEYS]    one-cycle press pulse per key
//   hex_val  in   [4]         nibble to display
//   hex_seg  out  [7]         active-low segments, bit0=a .. bit5=f, bit6=g
//   sat_in   in   [PRECISION] signed two's-complement value
//   sat_out  out  [8]         unsigned saturated result
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// bin2hex7seg: hex_val -> hex_seg, active-low, pattern listed g..a.
// Blank (1111111) and minus (0111111) are produced by callers, not here.
// ---------------------------------------------------------------------------
module bin2hex7seg (
    input  logic [3:0] hex_val,
    output logic [6:0] hex_seg
);
    always_comb begin
        hex_seg = 7'b1111111;
        case (hex_val)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            4'hF: hex_seg = 7'b0001110;
            default: hex_seg = 7'b1111111;
        endcase
    end
endmodule

// ---------------------------------------------------------------------------
// button_input: one key channel.
//   clk, reset : clock, async active-high reset
//   key_n      : raw active-low button (asynchronous)
//   pressed    : one-cycle pulse when the synchronized level falls
// Reset parks the history at "released" so a key held through reset still
// yields exactly one pulse once reset is removed.
// ---------------------------------------------------------------------------
module button_input (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed
);
    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            prev    <= 1'b1;
            pressed <= 1'b0;
        end else begin
            // synchronizer stage, then edge-history stage
            sync1   <= key_n;
            sync2   <= sync1;
            prev    <= sync2;
            // pulse on the 1 -> 0 transition of the synchronized level
            pressed <= prev & ~sync2;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// round_to_8_bit: clamp a signed PRECISION-bit value into 0..255.
//   sat_in  : signed input (callers pre-shift away fractional bits)
//   sat_out : unsigned 8-bit result
// The upper-limit test is a signed compare so that PRECISION = 9 (where no
// positive value exceeds 255) needs no special casing.
// ---------------------------------------------------------------------------
module round_to_8_bit #(
    parameter int PRECISION = 16
) (
    input  logic signed [PRECISION-1:0] sat_in,
    output logic        [7:0]           sat_out
);
    localparam logic signed [PRECISION-1:0] MAX8 = PRECISION'(255);

    function automatic logic [7:0] sat8(input logic signed [PRECISION-1:0] v);
        if (v[PRECISION-1])
            return 8'd0;
        else if (v > MAX8)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    always_comb begin
        sat_out = sat8(sat_in);
    end
endmodule

// ---------------------------------------------------------------------------
// ui_io_helpers: top-level bundle.
// ---------------------------------------------------------------------------
module ui_io_helpers #(
    parameter int PRECISION = 16,
    parameter int N_KEYS    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic        [N_KEYS-1:0]    key_n,
    output logic        [N_KEYS-1:0]    pressed,
    input  logic        [3:0]           hex_val,
    output logic        [6:0]           hex_seg,
    input  logic signed [PRECISION-1:0] sat_in,
    output logic        [7:0]           sat_out
);
    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        button_input u_btn (
            .clk     (clk),
            .reset   (reset),
            .key_n   (key_n[k]),
            .pressed (pressed[k])
        );
    end

    bin2hex7seg u_hex (
        .hex_val (hex_val),
        .hex_seg (hex_seg)
    );

    round_to_8_bit #(
        .PRECISION (PRECISION)
    ) u_sat (
        .sat_in  (sat_in),
        .sat_out (sat_out)
    );
endmodule

// File: tb/tb_ui_io_helpers.sv
module tb_ui_io_helpers;
    localparam int PRECISION = 16;
    localparam int N_KEYS    = 2;

    logic                        clk;
    logic                        reset;
    logic        [N_KEYS-1:0]    key_n;
    logic        [N_KEYS-1:0]    pressed;
    logic        [3:0]           hex_val;
    logic        [6:0]           hex_seg;
    logic signed [PRECISION-1:0] sat_in;
    logic        [7:0]           sat_out;

    ui_io_helpers #(.PRECISION(PRECISION), .N_KEYS(N_KEYS)) dut (
        .clk     (clk),
        .reset   (reset),
        .key_n   (key_n),
        .pressed (pressed),
        .hex_val (hex_val),
        .hex_seg (hex_seg),
        .sat_in  (sat_in),
        .sat_out (sat_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment table, g..a order.
    localparam logic [6:0] HEX_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam int N_SAT_DIR = 9;
    int sat_dir [N_SAT_DIR] = '{-1, -32768, 0, 100, 255, 256, 32767,
                                1600 >>> 4, (-48) >>> 4};

    typedef struct {
        logic [N_KEYS-1:0] prs;
        logic [6:0]        seg;
        logic [7:0]        sat;
        int                hv;
        int                sv;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    // Model history: every key_n sample taken at a clock edge since reset.
    // The synchronized level lags key_n by two edges; a press is reported on
    // the edge after that level falls from 1 to 0. Reset makes the history
    // look like a long run of "released".
    logic [N_KEYS-1:0] hist[$];

    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back({N_KEYS{1'b1}});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, step_no, act, req);
        end
    endtask

    function automatic logic [7:0] sat_ref(input int v);
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    // One clock: drive at negedge, predict the state just after the next
    // posedge, and hand the prediction to the monitor.
    task automatic step(input logic [N_KEYS-1:0] k, input logic r);
        exp_t e;
        int   sv;
        @(negedge clk);
        step_no++;
        key_n   = k;
        reset   = r;
        hex_val = (step_no < 40) ? 4'(step_no) : 4'($urandom_range(0, 15));
        if (step_no <= N_SAT_DIR) sv = sat_dir[step_no-1];
        else if ($urandom_range(0, 3) == 0) sv = sat_dir[$urandom_range(0, N_SAT_DIR-1)];
        else sv = $signed(16'($urandom()));
        sat_in = PRECISION'(sv);

        if (r) begin
            model_reset();
            e.prs = '0;
        end else begin
            hist.push_back(k);
            e.prs = hist[hist.size()-4] & ~hist[hist.size()-3];
            if (hist.size() > 8) void'(hist.pop_front());
        end
        e.seg = HEX_TBL[hex_val];
        e.sat = sat_ref(sv);
        e.hv  = int'(hex_val);
        e.sv  = sv;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one prediction per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pressed", 32'(pressed), 32'(e.prs));
                check($sformatf("hex_seg[%0h]", e.hv), 32'(hex_seg), 32'(e.seg));
                check($sformatf("sat_out[%0d]", e.sv), 32'(sat_out), 32'(e.sat));
            end
        end
    end

    initial begin
        logic [N_KEYS-1:0] k;
        reset   = 1'b1;
        key_n   = '1;
        hex_val = 4'h0;
        sat_in  = '0;
        model_reset();
        #1;
        check("reset_pressed", 32'(pressed), 32'd0);

        // held in reset, then released keys for 10 cycles
        repeat (2)  step(2'b11, 1'b1);
        repeat (10) step(2'b11, 1'b0);

        // key 0 held 5 cycles, then released
        repeat (5) step(2'b10, 1'b0);
        repeat (6) step(2'b11, 1'b0);

        // both keys on the same edge; pulse appears after the third edge
        repeat (3) step(2'b00, 1'b0);
        check("both_pulse", 32'(pressed), 32'd3);
        // reset mid-cycle while both are held clears the pulse at once
        reset = 1'b1;
        #1;
        check("async_rst_clear", 32'(pressed), 32'd0);
        model_reset();
        repeat (2) step(2'b00, 1'b1);
        repeat (5) step(2'b00, 1'b0);
        repeat (4) step(2'b11, 1'b0);

        // randomized keys with occasional reset
        k = '1;
        repeat (300) begin
            for (int b = 0; b < N_KEYS; b++)
                if ($urandom_range(0, 3) == 0) k[b] = ~k[b];
            step(k, ($urandom_range(0, 49) == 0));
        end

        repeat (2) @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
